frame_buffer_ctrl: RTL

FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

---
 rtl/frame_buffer_ctrl_pkg.sv | 26 ++
 rtl/frame_buffer_ctrl_if.sv | 39 +++
 rtl/frame_buffer_ctrl_slot_ring.sv | 61 ++++++
 rtl/frame_buffer_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/frame_buffer_ctrl_pkg.sv
// Shared definitions for the frame buffer controller: FSM state encodings,
// default slot stride and capture timeout, and the slot address helper.
package frame_buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_ARM  = 2'd1,
        C_WAIT = 2'd2
    } cap_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_LOCK = 1'b1
    } rd_state_e;

    localparam logic [29:0] DEF_BUF_STRIDE  = 30'h0080_0000;
    localparam logic [31:0] DEF_TIMEOUT_CYC = 32'd50_000_000;

    // Slot address = base + idx*stride, wrapping silently at 2^30.
    function automatic logic [29:0] slot_addr(input logic [29:0] base,
                                              input logic [3:0]  idx,
                                              input logic [29:0] stride);
        return base + stride * 30'(idx);
    endfunction

endpackage

// File: rtl/frame_buffer_ctrl_if.sv
// Bus bundle between the frame buffer controller and its environment.
// master: drives control, capture-block status and host handshake inputs.
// slave : the controller; drives trigger/slot address, read grant and status.
//   base_addr, capture_en, single_shot      control inputs
//   img_trigger, img_start_addr             capture arm request
//   img_frame_written, img_skipped          capture block status pulses
//   rd_req, rd_ack, rd_addr, rd_done        host slot lock handshake
//   buf_count, skip_cnt, timeout, cap_busy  status outputs
interface frame_buffer_ctrl_if;
    logic [29:0] base_addr;
    logic        capture_en;
    logic        single_shot;
    logic        img_trigger;
    logic [29:0] img_start_addr;
    logic        img_frame_written;
    logic        img_skipped;
    logic        rd_req;
    logic        rd_ack;
    logic [29:0] rd_addr;
    logic        rd_done;
    logic [3:0]  buf_count;
    logic [15:0] skip_cnt;
    logic        timeout;
    logic        cap_busy;

    modport master (
        output base_addr, capture_en, single_shot,
        output img_frame_written, img_skipped, rd_req, rd_done,
        input  img_trigger, img_start_addr, rd_ack, rd_addr,
        input  buf_count, skip_cnt, timeout, cap_busy
    );

    modport slave (
        input  base_addr, capture_en, single_shot,
        input  img_frame_written, img_skipped, rd_req, rd_done,
        output img_trigger, img_start_addr, rd_ack, rd_addr,
        output buf_count, skip_cnt, timeout, cap_busy
    );
endinterface

// File: rtl/frame_buffer_ctrl_slot_ring.sv
// Slot ring bookkeeping: write/read pointers modulo NUM_BUFS and the count
// of filled, unreleased slots.
//   clk, reset   clock, async active-high reset
//   commit_i     a slot was filled (advance write pointer)
//   release_i    the host released a slot (advance read pointer)
//   wr_ptr_o     slot to arm next
//   rd_ptr_o     oldest filled slot
//   count_o      filled slots 0..NUM_BUFS
//   full_o       count_o == NUM_BUFS
//   empty_o      count_o == 0
module frame_slot_ring #(
    parameter int unsigned NUM_BUFS = 4,
    parameter int unsigned PTR_W    = $clog2(NUM_BUFS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             commit_i,
    input  logic             release_i,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [3:0]       count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [3:0]       cnt_q, cnt_d;

    // NUM_BUFS is a power of two, so pointer wrap is the natural overflow.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (commit_i)  wr_d = wr_q + PTR_W'(1);
        if (release_i) rd_d = rd_q + PTR_W'(1);
        case ({commit_i, release_i})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign wr_ptr_o = wr_q;
    assign rd_ptr_o = rd_q;
    assign count_o  = cnt_q;
    assign full_o   = (cnt_q == 4'(NUM_BUFS));
    assign empty_o  = (cnt_q == '0);

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Frame buffer controller: arms a capture block into a ring of DDR frame
// slots and lends the oldest filled slot to a host.
//   clk    sole clock
//   reset  asynchronous, active-high
//   bus    frame_buffer_ctrl_if.slave (control, capture and host signals)
module frame_buffer_ctrl
    import frame_buffer_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BUFS    = 4,
    parameter logic [29:0] BUF_STRIDE  = DEF_BUF_STRIDE,
    parameter logic [31:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 reset,
    frame_buffer_ctrl_if.slave   bus
);

    localparam int unsigned PTR_W = $clog2(NUM_BUFS);

    cap_state_e  cap_q, cap_d;
    logic        pend_q, pend_d;
    logic [29:0] base_q, base_d;
    logic [29:0] start_q, start_d;
    logic [31:0] timer_q, timer_d;
    logic        commit_s, timeout_s;

    rd_state_e   rd_q, rd_d;
    logic        rd_ack_q, rd_ack_d;
    logic [29:0] rd_addr_q, rd_addr_d;
    logic        rel_s;

    logic [15:0] skip_q, skip_d;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [3:0]       count;
    logic             full, empty;

    frame_slot_ring #(
        .NUM_BUFS (NUM_BUFS),
        .PTR_W    (PTR_W)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .commit_i  (commit_s),
        .release_i (rel_s),
        .wr_ptr_o  (wr_ptr),
        .rd_ptr_o  (rd_ptr),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty)
    );

    // Capture FSM. Arming never happens while full, so the armed slot can
    // never be the slot currently locked by the host.
    always_comb begin
        cap_d     = cap_q;
        pend_d    = pend_q;
        base_d    = base_q;
        start_d   = start_q;
        timer_d   = timer_q;
        commit_s  = 1'b0;
        timeout_s = 1'b0;
        unique case (cap_q)
            C_IDLE: begin
                if ((bus.capture_en || bus.single_shot || pend_q) && !full) begin
                    cap_d   = C_ARM;
                    base_d  = bus.base_addr;
                    start_d = slot_addr(bus.base_addr, 4'(wr_ptr), BUF_STRIDE);
                end
            end
            C_ARM: begin
                cap_d   = C_WAIT;
                timer_d = '0;
            end
            C_WAIT: begin
                // A frame landing on the last allowed cycle still commits.
                if (bus.img_frame_written) begin
                    commit_s = 1'b1;
                    cap_d    = C_IDLE;
                end else if (timer_q == TIMEOUT_CYC - 32'd1) begin
                    timeout_s = 1'b1;
                    cap_d     = C_IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: cap_d = C_IDLE;
        endcase
        // A single_shot that launches the capture directly is consumed;
        // otherwise it waits, one deep, for the next arm.
        if (cap_q == C_IDLE && cap_d == C_ARM) begin
            pend_d = 1'b0;
        end else if (bus.single_shot) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_q   <= C_IDLE;
            pend_q  <= 1'b0;
            base_q  <= '0;
            start_q <= '0;
            timer_q <= '0;
        end else begin
            cap_q   <= cap_d;
            pend_q  <= pend_d;
            base_q  <= base_d;
            start_q <= start_d;
            timer_q <= timer_d;
        end
    end

    // Read FSM: rd_ack is registered, one cycle after rd_req.
    always_comb begin
        rd_d      = rd_q;
        rd_ack_d  = 1'b0;
        rd_addr_d = rd_addr_q;
        rel_s     = 1'b0;
        case (rd_q)
            R_IDLE: begin
                if (bus.rd_req && !empty) begin
                    rd_d      = R_LOCK;
                    rd_ack_d  = 1'b1;
                    rd_addr_d = slot_addr(base_q, 4'(rd_ptr), BUF_STRIDE);
                end
            end
            R_LOCK: begin
                if (bus.rd_done) begin
                    rel_s = 1'b1;
                    rd_d  = R_IDLE;
                end
            end
            default: rd_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q      <= R_IDLE;
            rd_ack_q  <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_q      <= rd_d;
            rd_ack_q  <= rd_ack_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    always_comb begin
        skip_d = skip_q;
        if (bus.img_skipped && (skip_q != '1)) skip_d = skip_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) skip_q <= '0;
        else       skip_q <= skip_d;
    end

    assign bus.img_trigger    = (cap_q == C_ARM);
    assign bus.img_start_addr = start_q;
    assign bus.timeout        = timeout_s;
    assign bus.cap_busy       = (cap_q != C_IDLE);
    assign bus.rd_ack         = rd_ack_q;
    assign bus.rd_addr        = rd_addr_q;
    assign bus.buf_count      = count;
    assign bus.skip_cnt       = skip_q;

endmodule
